// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing for the 5-stage core: load-use bubbles, branch
// flushes, multi-cycle MDU start/done handshake with watchdog, stall counting.
module hazard_stall_controller #(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_ex_MemRead,
    input  logic [4:0]       id_ex_write_reg,
    input  logic             id_ex_is_mdu,
    input  logic             ex_branch_taken,
    input  logic             mdu_done,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mdu_start,
    output logic             mdu_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {
        RUN,
        MDU_WAIT
    } state_t;

    localparam logic [9:0] WAIT_LAST = 10'(MDU_TIMEOUT - 1);

    state_t     state;
    logic [9:0] wait_cnt;
    logic       load_use;
    logic       wait_last;
    logic       release_mdu;

    assign load_use = id_ex_MemRead && (id_ex_write_reg != 5'd0) &&
                      ((id_uses_rs && (id_rs == id_ex_write_reg)) ||
                       (id_uses_rt && (id_rt == id_ex_write_reg)));

    assign wait_last   = (wait_cnt == WAIT_LAST);
    assign release_mdu = (state == MDU_WAIT) && (mdu_done || wait_last);

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mdu_start    = 1'b0;
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (id_ex_is_mdu) begin
                        mdu_start    = 1'b1;
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_flush = 1'b1;
                    end else if (ex_branch_taken) begin
                        // wrong-path ID instruction: any load-use is moot
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    if (!release_mdu) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_flush = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mdu_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (!pc_write && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            case (state)
                RUN: begin
                    if (id_ex_is_mdu) begin
                        state    <= MDU_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MDU_WAIT: begin
                    if (mdu_done) begin
                        state <= RUN;
                    end else if (wait_last) begin
                        state       <= RUN;
                        mdu_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 10'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller with MDU_TIMEOUT=8.
// ctl vector: {pc_write,if_id_write,id_ex_write,if_id_flush,id_ex_flush,ex_mem_flush,mdu_start}
module tb_hazard_stall_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, id_ex_write_reg;
    logic        id_uses_rs, id_uses_rt, id_ex_MemRead;
    logic        id_ex_is_mdu, ex_branch_taken, mdu_done;
    logic        pc_write, if_id_write, id_ex_write;
    logic        if_id_flush, id_ex_flush, ex_mem_flush;
    logic        mdu_start, mdu_timeout;
    logic [31:0] stall_cycles;

    int checks = 0;
    int failures = 0;

    localparam logic [6:0] C_RST  = 7'b000_111_0;
    localparam logic [6:0] C_RUN  = 7'b111_000_0;
    localparam logic [6:0] C_LU   = 7'b001_010_0;
    localparam logic [6:0] C_BR   = 7'b111_110_0;
    localparam logic [6:0] C_STRT = 7'b000_001_1;
    localparam logic [6:0] C_WAIT = 7'b000_001_0;

    hazard_stall_controller #(.MDU_TIMEOUT(8), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_ex_MemRead(id_ex_MemRead), .id_ex_write_reg(id_ex_write_reg),
        .id_ex_is_mdu(id_ex_is_mdu), .ex_branch_taken(ex_branch_taken),
        .mdu_done(mdu_done),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_write(id_ex_write), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .mdu_start(mdu_start), .mdu_timeout(mdu_timeout),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctl();
        return {25'd0, pc_write, if_id_write, id_ex_write,
                if_id_flush, id_ex_flush, ex_mem_flush, mdu_start};
    endfunction

    task automatic idle();
        id_rs = 5'd1; id_rt = 5'd2;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_ex_MemRead = 1'b0; id_ex_write_reg = 5'd0;
        id_ex_is_mdu = 1'b0; ex_branch_taken = 1'b0; mdu_done = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #1;
        check("rst_ctl", ctl(), {25'd0, C_RST});
        tick();
        tick();
        check("rst_stall", stall_cycles, 0);
        check("rst_tmo", {31'd0, mdu_timeout}, 0);
        reset = 1'b0;
        #1;
        check("run_ctl", ctl(), {25'd0, C_RUN});

        // load to $0 with ID reading $0
        id_ex_MemRead = 1'b1; id_ex_write_reg = 5'd0;
        id_rs = 5'd0; id_uses_rs = 1'b1;
        #1;
        check("lu_r0", ctl(), {25'd0, C_RUN});
        tick();
        // rt matches but is not read
        id_ex_write_reg = 5'd8; id_rs = 5'd3;
        id_rt = 5'd8; id_uses_rt = 1'b0;
        #1;
        check("lu_rt_unused", ctl(), {25'd0, C_RUN});
        tick();
        check("no_stall_cnt", stall_cycles, 0);

        // real load-use via rs
        id_rs = 5'd8;
        #1;
        check("lu_ctl", ctl(), {25'd0, C_LU});
        tick();
        idle();
        #1;
        check("lu_after", ctl(), {25'd0, C_RUN});
        check("lu_cnt", stall_cycles, 1);

        // load-use via rt, branch taken wins
        id_ex_MemRead = 1'b1; id_ex_write_reg = 5'd8;
        id_rt = 5'd8; id_uses_rt = 1'b1; ex_branch_taken = 1'b1;
        #1;
        check("br_ctl", ctl(), {25'd0, C_BR});
        tick();
        check("br_cnt", stall_cycles, 1);

        // MDU op; branch ignored, done after 5 wait cycles
        idle();
        id_ex_is_mdu = 1'b1; ex_branch_taken = 1'b1;
        #1;
        check("mdu_start", ctl(), {25'd0, C_STRT});
        tick();
        ex_branch_taken = 1'b0;
        id_ex_MemRead = 1'b1; id_ex_write_reg = 5'd8;
        id_rs = 5'd8; id_uses_rs = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("mdu_wait%0d", i), ctl(), {25'd0, C_WAIT});
            tick();
        end
        idle();
        id_ex_is_mdu = 1'b1; mdu_done = 1'b1;
        #1;
        check("mdu_rel", ctl(), {25'd0, C_RUN});
        tick();
        idle();
        mdu_done = 1'b1;
        #1;
        check("done_in_run", ctl(), {25'd0, C_RUN});
        check("mdu_cnt", stall_cycles, 7);
        tick();
        check("no_tmo", {31'd0, mdu_timeout}, 0);

        // watchdog: done never arrives
        idle();
        id_ex_is_mdu = 1'b1;
        #1;
        check("tmo_start", ctl(), {25'd0, C_STRT});
        tick();
        for (int i = 0; i < 7; i++) begin
            #1;
            check($sformatf("tmo_wait%0d", i), ctl(), {25'd0, C_WAIT});
            tick();
        end
        #1;
        check("tmo_rel", ctl(), {25'd0, C_RUN});
        check("tmo_pre", {31'd0, mdu_timeout}, 0);
        tick();
        check("tmo_flag", {31'd0, mdu_timeout}, 1);
        check("tmo_cnt", stall_cycles, 15);
        // back-to-back op: fresh start right after release
        check("b2b_start", ctl(), {25'd0, C_STRT});
        tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("b2b_wait%0d", i), ctl(), {25'd0, C_WAIT});
            tick();
        end
        check("tmo_sticky", {31'd0, mdu_timeout}, 1);
        check("b2b_cnt", stall_cycles, 18);

        // reset mid-wait
        reset = 1'b1;
        #1;
        check("rst_wait_ctl", ctl(), {25'd0, C_RST});
        tick();
        check("rst2_ctl", ctl(), {25'd0, C_RST});
        check("rst2_stall", stall_cycles, 0);
        check("rst2_tmo", {31'd0, mdu_timeout}, 0);
        reset = 1'b0;
        id_ex_is_mdu = 1'b0;
        #1;
        check("rst2_run", ctl(), {25'd0, C_RUN});
        tick();
        check("rst2_cnt", stall_cycles, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Generates PC/IF-ID write enables, bubble and flush controls for load-use hazards and taken branches.
- Sequences a multi-cycle multiply/divide unit (MDU) sitting in EX through a start/done handshake with a watchdog timeout.
- Counts stall cycles. Complements the forwarding logic: it covers every hazard that forwarding cannot resolve.

Parameters:
- MDU_TIMEOUT, 64: maximum cycles spent in MDU_WAIT before forced release; legal range 2..1023.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of instruction in ID.
- id_rt  in  5  rt field of instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_ex_MemRead  in  1  instruction in EX is a load.
- id_ex_write_reg  in  5  destination register of instruction in EX.
- id_ex_is_mdu  in  1  instruction in EX is a multi-cycle MDU op.
- ex_branch_taken  in  1  branch/jump in EX resolved taken.
- mdu_done  in  1  MDU result valid; single-cycle pulse.
- pc_write  out  1  PC register write enable.
- if_id_write  out  1  IF/ID register write enable.
- id_ex_write  out  1  ID/EX register write enable (hold EX).
- if_id_flush  out  1  zero IF/ID contents.
- id_ex_flush  out  1  load a bubble into ID/EX.
- ex_mem_flush  out  1  load a bubble into EX/MEM.
- mdu_start  out  1  one-cycle MDU start pulse.
- mdu_timeout  out  1  sticky watchdog error flag.
- stall_cycles  out  CNT_W  cycles with pc_write=0, saturating.

Behaviour:
- States: RUN, MDU_WAIT. Reset sets state=RUN, wait counter=0, mdu_timeout=0, stall_cycles=0.
- While reset=1, outputs are forced to: pc_write=0, if_id_write=0, id_ex_write=0, all flushes=1, mdu_start=0.
- Control outputs are combinational from state and inputs (same-cycle response). State, counters and flags are registered.
- Default in RUN: pc_write=if_id_write=id_ex_write=1, all flushes=0, mdu_start=0.
- Load-use hazard term: id_ex_MemRead & id_ex_write_reg!=0 & ((id_uses_rs & id_rs==id_ex_write_reg) | (id_uses_rt & id_rt==id_ex_write_reg)).
- Priority in RUN is MDU > branch > load-use.
  - MDU (id_ex_is_mdu=1): mdu_start=1, pc_write=if_id_write=id_ex_write=0, ex_mem_flush=1; next state MDU_WAIT with wait counter=0. ex_branch_taken is ignored.
  - Branch (ex_branch_taken=1): pc_write=1, if_id_flush=1, id_ex_flush=1. A concurrent load-use hazard is suppressed because the ID instruction is wrong-path.
  - Load-use: pc_write=if_id_write=0, id_ex_flush=1. Exactly one bubble results, because the hazard term clears once the load advances.
- MDU_WAIT:
  - Stall outputs: pc_write=if_id_write=id_ex_write=0, ex_mem_flush=1, mdu_start=0. Load-use and branch inputs are ignored.
  - mdu_done=1: release in that same cycle (all enables 1, ex_mem_flush=0) so the MDU result enters EX/MEM; next state RUN.
  - No done and wait counter==MDU_TIMEOUT-1: release identically, set mdu_timeout=1 (sticky until reset), next state RUN.
  - Otherwise: increment the wait counter.
  - mdu_done while in RUN is ignored.
- Back-to-back MDU ops: after release, if a new MDU op is in EX in RUN, a new mdu_start pulse is issued immediately. The minimum gap between pulses is 2 cycles.
- stall_cycles increments on every non-reset cycle with pc_write=0 and holds at 2^CNT_W-1.
- Reset asserted mid-MDU_WAIT: next cycle state=RUN and counters/flag cleared. No mdu_start is issued while reset=1.

Test Plan:
- Load-use: EX lw to $8, ID add using rs=$8 -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; next cycle all enables 1; stall_cycles=1.
- Load to $0 with ID reading $0, or ID reading rt=$8 with id_uses_rt=0 -> no stall, stall_cycles stays 0.
- Taken branch in EX while load-use is also true -> if_id_flush=1, id_ex_flush=1, pc_write=1, no stall that cycle.
- MDU op, mdu_done 5 cycles after mdu_start -> mdu_start high exactly 1 cycle; stall held 5 more cycles; release on the done cycle; stall_cycles=6.
- MDU_TIMEOUT=8, mdu_done never arrives -> release after 8 cycles in MDU_WAIT, mdu_timeout=1 stays set; a second MDU op issues a fresh mdu_start.
- reset pulsed during MDU_WAIT -> state RUN, stall_cycles=0, mdu_timeout=0; outputs forced to their reset values while reset=1.
